// File: rtl/fetch_pc_gen.sv
// Fetch front end: owns the fetch PC, issues req/ack reads to instruction
// memory, buffers returned words in a 2-entry queue and presents the head
// to the fetch_instruction stage. A taken branch flushes the queue and
// drops any stale fetch still in flight.
module fetch_pc_gen #(
    parameter int              WORD     = 32,
    parameter int              ADDR     = 32,
    parameter int              PC_STEP  = 4,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_o,
    output logic [ADDR-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [WORD-1:0] imem_data_i,
    output logic            v_o,
    output logic [ADDR-1:0] pc_o,
    output logic [WORD-1:0] inst_o,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [ADDR-1:0] branch_target_i
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state, state_next;
    logic [ADDR-1:0] pc_r;
    logic [ADDR-1:0] drain_addr;   // address of the stale fetch after a redirect
    logic [1:0]      count;
    logic [1:0]      occ_next;
    logic [ADDR-1:0] q_pc   [2];
    logic [WORD-1:0] q_inst [2];
    logic            ack, push, pop;
    logic            wr_idx;

    assign imem_req_o  = (state != IDLE);
    assign imem_addr_o = (state == DRAIN) ? drain_addr : pc_r;
    assign ack         = imem_req_o & imem_ack_i;
    assign push        = (state == REQ) & ack & ~branch_i;
    assign v_o         = (count != 2'd0);
    assign pop         = v_o & ~stall_i;
    assign occ_next    = count - {1'b0, pop} + {1'b0, push};
    assign pc_o        = q_pc[0];
    assign inst_o      = q_inst[0];
    // New entry lands behind whatever survives this cycle's pop.
    assign wr_idx      = (count == 2'd2) || (count == 2'd1 && !pop);

    // Next-state logic; a redirect overrides the normal flow in every state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (occ_next <= 2'd1) state_next = REQ;
            REQ:     if (ack && occ_next == 2'd2) state_next = IDLE;
            DRAIN:   if (ack) state_next = REQ;
            default: state_next = IDLE;
        endcase
        if (branch_i) begin
            // Only an un-acked request leaves a stale fetch to wait out.
            if ((state == REQ || state == DRAIN) && !ack) state_next = DRAIN;
            else                                          state_next = REQ;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Fetch PC and the held address of an abandoned in-flight fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r       <= RESET_PC;
            drain_addr <= '0;
        end else if (branch_i) begin
            pc_r <= branch_target_i;
            if (state == REQ && !ack) drain_addr <= pc_r;
        end else if (push) begin
            pc_r <= pc_r + ADDR'(PC_STEP);
        end
    end

    // Two-entry in-order queue; head is always slot 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= 2'd0;
            q_pc[0]   <= '0;
            q_pc[1]   <= '0;
            q_inst[0] <= '0;
            q_inst[1] <= '0;
        end else if (branch_i) begin
            count <= 2'd0;
        end else begin
            if (pop) begin
                q_pc[0]   <= q_pc[1];
                q_inst[0] <= q_inst[1];
            end
            if (push) begin
                q_pc[wr_idx]   <= pc_r;
                q_inst[wr_idx] <= imem_data_i;
            end
            count <= occ_next;
        end
    end

    // The issue rule keeps REQ below two entries, so a push never meets a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && count == 2'd2));

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: stimulus pushes the expected memory
// addresses and delivered PCs; a memory model and an output monitor pop and
// compare as the DUT presents them.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        v_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = '0;

    // Second instance for the PC wrap case: ack tied to req, data = address.
    logic        req2;
    logic [31:0] addr2;
    logic        v2;
    logic [31:0] pc2;
    logic [31:0] inst2;

    int errors = 0;
    int checks = 0;
    int cyc_no = 0;
    int lat = 0;
    bit mem_en = 1'b0;
    int wait_cnt = 0;

    logic [31:0] exp_pc[$];
    logic [31:0] exp_addr[$];

    fetch_pc_gen dut (
        .clk(clk), .reset(reset),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .v_o(v_o), .pc_o(pc_o), .inst_o(inst_o),
        .stall_i(stall_i), .branch_i(branch_i), .branch_target_i(branch_target_i)
    );

    fetch_pc_gen #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_ack_i(req2), .imem_data_i(addr2),
        .v_o(v2), .pc_o(pc2), .inst_o(inst2),
        .stall_i(1'b0), .branch_i(1'b0), .branch_target_i(32'h0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    // Memory model: decides at the falling edge whether to ack at the next rising edge.
    always @(negedge clk) begin
        imem_ack_i  = 1'b0;
        imem_data_i = $urandom;
        if (!reset || !imem_req_o) begin
            wait_cnt = 0;
        end else if (mem_en) begin
            if (wait_cnt >= lat) begin
                imem_ack_i  = 1'b1;
                imem_data_i = inst_of(imem_addr_o);
                wait_cnt    = 0;
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_addr: actual %h, no request expected (cycle %0d)", imem_addr_o, cyc_no);
                end else begin
                    check("ack_addr", imem_addr_o, exp_addr.pop_front());
                end
            end else begin
                wait_cnt++;
            end
        end
    end

    // Output monitor: every accepted head must match the next expected PC.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset && v_o && !stall_i) begin
            if (exp_pc.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_pc: actual %h, no output expected (cycle %0d)", pc_o, cyc_no);
            end else begin
                e = exp_pc.pop_front();
                check("out_pc", pc_o, e);
                check("out_inst", inst_o, inst_of(e));
            end
        end
    end

    task automatic adv(input int c);
        while (cyc_no < c) begin
            @(posedge clk);
            #1;
            cyc_no++;
        end
    endtask

    // Ends in cycle 1 (first cycle out of reset).
    task automatic start_test(input int l, input bit en);
        reset           = 1'b0;
        stall_i         = 1'b0;
        branch_i        = 1'b0;
        branch_target_i = '0;
        lat             = l;
        mem_en          = en;
        exp_pc.delete();
        exp_addr.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset  = 1'b1;
        cyc_no = 1;
    endtask

    task automatic push_range(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_pc.push_back(base + 32'(4 * i));
            exp_addr.push_back(base + 32'(4 * i));
        end
    endtask

    task automatic check_drained(input string name);
        check({name, "_left_pc"}, 32'(exp_pc.size()), 32'd0);
        check({name, "_left_addr"}, 32'(exp_addr.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values while reset is held.
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_v", 32'(v_o), 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_inst", inst_o, 32'd0);

        // 1: streaming with zero-latency ack, then reset mid-request.
        start_test(0, 1'b1);
        push_range(32'h0, 4);
        check("t1_idle_req", 32'(imem_req_o), 32'd0);
        adv(2); check("t1_addr0", imem_addr_o, 32'h0); check("t1_v_c2", 32'(v_o), 32'd0);
        adv(3); check("t1_addr4", imem_addr_o, 32'h4); check("t1_v_c3", 32'(v_o), 32'd1);
        adv(4); check("t1_addr8", imem_addr_o, 32'h8);
        adv(5); check("t1_addrC", imem_addr_o, 32'hC);
        adv(6); mem_en = 1'b0;
        adv(8); check_drained("t1");
        check("t1_req_before_rst", 32'(imem_req_o), 32'd1);
        reset = 1'b0; #1;
        check("t1_rst_req", 32'(imem_req_o), 32'd0);
        check("t1_rst_v", 32'(v_o), 32'd0);
        check("t1_rst_pc", pc_o, 32'd0);
        check("t1_rst_inst", inst_o, 32'd0);

        // 2: stall for five cycles fills the queue and parks the requester.
        start_test(0, 1'b1);
        push_range(32'h0, 5);
        adv(5); stall_i = 1'b1;
        for (int c = 6; c <= 9; c++) begin
            adv(c);
            check("t2_stall_req", 32'(imem_req_o), 32'd0);
            check("t2_stall_v", 32'(v_o), 32'd1);
            check("t2_stall_head", pc_o, 32'h8);
        end
        adv(10); stall_i = 1'b0;
        adv(11); check("t2_resume_req", 32'(imem_req_o), 32'd1); check("t2_resume_addr", imem_addr_o, 32'h10);
        adv(12); mem_en = 1'b0;
        adv(15); check_drained("t2");

        // 3: three-cycle ack latency.
        start_test(2, 1'b1);
        push_range(32'h0, 2);
        for (int c = 2; c <= 4; c++) begin
            adv(c);
            check("t3_addr_hold0", imem_addr_o, 32'h0);
            check("t3_v_wait0", 32'(v_o), 32'd0);
        end
        adv(5); check("t3_v_c5", 32'(v_o), 32'd1); check("t3_addr_c5", imem_addr_o, 32'h4);
        adv(6); check("t3_v_c6", 32'(v_o), 32'd0); check("t3_addr_c6", imem_addr_o, 32'h4);
        adv(7); check("t3_v_c7", 32'(v_o), 32'd0); check("t3_addr_c7", imem_addr_o, 32'h4);
        adv(8); check("t3_v_c8", 32'(v_o), 32'd1); mem_en = 1'b0;
        adv(10); check_drained("t3");

        // 4: redirect with 0x20 outstanding, second redirect during DRAIN.
        start_test(0, 1'b1);
        push_range(32'h0, 8);
        exp_addr.push_back(32'h20);
        exp_pc.push_back(32'h100);
        exp_addr.push_back(32'h100);
        adv(10); mem_en = 1'b0;
        adv(11); check("t4_pending_addr", imem_addr_o, 32'h20);
        branch_i = 1'b1; branch_target_i = 32'h180;
        adv(12); check("t4_drain_addr", imem_addr_o, 32'h20); check("t4_drain_v", 32'(v_o), 32'd0);
        branch_target_i = 32'h100;
        adv(13); branch_i = 1'b0; mem_en = 1'b1;
        check("t4_drain_req", 32'(imem_req_o), 32'd1); check("t4_drain_addr2", imem_addr_o, 32'h20);
        adv(14); check("t4_target_addr", imem_addr_o, 32'h100); check("t4_target_v", 32'(v_o), 32'd0);
        adv(15); mem_en = 1'b0; check("t4_target_out_v", 32'(v_o), 32'd1);
        adv(17); check_drained("t4");

        // 5: redirect with a full queue, then redirect coincident with an ack.
        start_test(0, 1'b1);
        push_range(32'h0, 2);
        exp_addr.push_back(32'h8);
        exp_addr.push_back(32'hC);
        push_range(32'h200, 2);
        exp_addr.push_back(32'h208);
        exp_pc.push_back(32'h280);
        exp_addr.push_back(32'h280);
        adv(5); stall_i = 1'b1;
        adv(7); check("t5_full_req", 32'(imem_req_o), 32'd0); check("t5_full_head", pc_o, 32'h8);
        branch_i = 1'b1; branch_target_i = 32'h200;
        adv(8); branch_i = 1'b0; stall_i = 1'b0;
        check("t5_flush_v", 32'(v_o), 32'd0); check("t5_new_addr", imem_addr_o, 32'h200);
        adv(9); check("t5_new_v", 32'(v_o), 32'd1);
        adv(10); branch_i = 1'b1; branch_target_i = 32'h280;
        adv(11); branch_i = 1'b0;
        check("t5_ackbr_v", 32'(v_o), 32'd0); check("t5_ackbr_addr", imem_addr_o, 32'h280);
        adv(12); mem_en = 1'b0;
        adv(14); check_drained("t5");

        // 6: PC wrap on the second instance, then reset mid-request.
        start_test(0, 1'b0);
        adv(2); check("t6_addr_top", addr2, 32'hFFFF_FFFC); check("t6_req", 32'(req2), 32'd1);
        adv(3); check("t6_addr_wrap", addr2, 32'h0);
        check("t6_head_pc", pc2, 32'hFFFF_FFFC); check("t6_head_inst", inst2, 32'hFFFF_FFFC);
        adv(4); check("t6_head_pc2", pc2, 32'h0);
        reset = 1'b0; #1;
        check("t6_rst_req", 32'(req2), 32'd0);
        check("t6_rst_v", 32'(v2), 32'd0);
        check("t6_rst_pc", pc2, 32'd0);
        check("t6_rst_inst", inst2, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
